// File: rtl/serializer_param.sv
// Parallel-to-serial converter: a one-word holding register feeds a WIDTH-bit shift register.
// Idle words fill the gaps, so every word on the link starts at a fixed boundary.
module serializer_param #(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC)
) (
  input  logic             dclk,
  input  logic             default_values,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             valid_out,
  output logic             sof_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] load_word;
  logic             hold_full;
  logic             word_is_data;
  logic [CNT_W-1:0] cnt;
  logic             boundary;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign ready_out = !hold_full;
  assign valid_out = word_is_data;
  assign accept    = valid_in && !hold_full;
  assign boundary  = enable && (cnt == LAST);
  assign load_word = hold_full ? hold_reg : IDLE_WORD;

  always_ff @(posedge dclk or posedge default_values) begin
    if (default_values) begin
      hold_full    <= 1'b0;
      cnt          <= LAST;
      data_out     <= 1'b0;
      word_is_data <= 1'b0;
      sof_out      <= 1'b0;
    end else begin
      // A full holding register cannot accept, so the two branches never collide.
      if (boundary && hold_full)
        hold_full <= 1'b0;
      else if (accept)
        hold_full <= 1'b1;

      if (boundary) begin
        cnt          <= '0;
        sof_out      <= 1'b1;
        word_is_data <= hold_full;
        data_out     <= first_bit(load_word);
      end else if (enable) begin
        cnt      <= cnt + 1'b1;
        sof_out  <= 1'b0;
        data_out <= first_bit(shreg);
      end
    end
  end

  // Data registers carry no reset: hold_full and cnt decide when their contents matter.
  always_ff @(posedge dclk) begin
    if (accept)
      hold_reg <= data_in;
    if (boundary)
      shreg <= advance(load_word);
    else if (enable)
      shreg <= advance(shreg);
  end

endmodule

// File: tb/tb_serializer_param.sv
// Bench for serializer_param: an 8-bit MSB-first instance and a 10-bit LSB-first instance.
module tb_serializer_param;

  logic       dclk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, data_out, valid_out, sof_out;

  logic       en10;
  logic [9:0] din10;
  logic       vin10;
  logic       rdy10, dout10, vout10, sof10;

  int checks   = 0;
  int failures = 0;

  // Expected serial stream entries: {data_out, valid_out, sof_out}
  logic [2:0] exp_q[$];

  always #5 dclk = ~dclk;

  serializer_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
    .dclk(dclk), .default_values(rst), .enable(enable), .data_in(data_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .sof_out(sof_out)
  );

  serializer_param #(.WIDTH(10), .MSB_FIRST(1'b0)) u_dut10 (
    .dclk(dclk), .default_values(rst), .enable(en10), .data_in(din10),
    .valid_in(vin10), .ready_out(rdy10), .data_out(dout10),
    .valid_out(vout10), .sof_out(sof10)
  );

  task automatic push_bits(input logic [15:0] w, input int n, input bit msb, input bit v);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(msb ? w[n-1-i] : w[i]), v, (i == 0)});
  endtask

  // Present a word on the 8-bit instance until accepted; returns with valid_in low.
  task automatic send_word(input logic [7:0] w, output bit acc);
    acc = 1'b0;
    data_in = w;
    valid_in = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      if (ready_out) begin
        @(posedge dclk);
        acc = 1'b1;
      end else
        @(negedge dclk);
    end
    #1 valid_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; valid_in = 1'b0; data_in = '0;
    en10 = 1'b1; vin10 = 1'b0; din10 = '0;
    #3;
    checks++;
    if ({data_out, valid_out, sof_out} !== 3'b000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=000", {data_out, valid_out, sof_out});
    end
    checks++;
    if (ready_out !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", ready_out);
    end
    checks++;
    if ({dout10, vout10, sof10, rdy10} !== 4'b0001) begin
      failures++; $display("FAIL reset_w10 got=%b exp=0001", {dout10, vout10, sof10, rdy10});
    end
    @(negedge dclk) rst = 1'b0;
  endtask

  task automatic test_idle;
    logic [2:0] e;
    push_bits(16'h00BC, 8, 1'b1, 1'b0);
    push_bits(16'h00BC, 8, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(posedge dclk); @(negedge dclk);
      e = exp_q.pop_front();
      checks++;
      if ({data_out, valid_out, sof_out} !== e) begin
        failures++; $display("FAIL idle_bit%0d got=%b exp=%b", i, {data_out, valid_out, sof_out}, e);
      end
      checks++;
      if (ready_out !== 1'b1) begin
        failures++; $display("FAIL idle_ready%0d got=%b exp=1", i, ready_out);
      end
    end
  endtask

  task automatic test_single_word;
    bit acc, found;
    logic [2:0] e;
    send_word(8'hA5, acc);
    checks++;
    if (!acc) begin
      failures++; $display("FAIL single_accept got=0 exp=1");
    end
    push_bits(16'h00A5, 8, 1'b1, 1'b1);
    found = 1'b0;
    for (int t = 0; t < 24 && !found; t++) begin
      @(posedge dclk); @(negedge dclk);
      found = sof_out && valid_out;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL single_start got=timeout exp=sof"); exp_q.delete();
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) begin @(posedge dclk); @(negedge dclk); end
        e = exp_q.pop_front();
        checks++;
        if ({data_out, valid_out, sof_out} !== e) begin
          failures++; $display("FAIL single_bit%0d got=%b exp=%b", i, {data_out, valid_out, sof_out}, e);
        end
      end
      @(posedge dclk); @(negedge dclk);
      checks++;
      if ({data_out, valid_out, sof_out} !== 3'b101) begin
        failures++; $display("FAIL single_idle_after got=%b exp=101", {data_out, valid_out, sof_out});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words[3] = '{8'h01, 8'h80, 8'hFF};
    fork
      begin : producer
        bit acc;
        for (int k = 0; k < 3; k++) begin
          push_bits({8'h00, words[k]}, 8, 1'b1, 1'b1);
          send_word(words[k], acc);
          checks++;
          if (!acc) begin
            failures++; $display("FAIL b2b_accept%0d got=0 exp=1", k);
          end
        end
      end
      begin : consumer
        bit found;
        logic [2:0] e;
        logic exp_rdy;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
          @(posedge dclk); @(negedge dclk);
          found = sof_out && valid_out;
        end
        checks++;
        if (!found) begin
          failures++; $display("FAIL b2b_start got=timeout exp=sof");
        end else begin
          for (int i = 0; i < 24; i++) begin
            if (i > 0) begin @(posedge dclk); @(negedge dclk); end
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL b2b_queue%0d got=empty exp=entry", i);
            end else begin
              e = exp_q.pop_front();
              if ({data_out, valid_out, sof_out} !== e) begin
                failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, {data_out, valid_out, sof_out}, e);
              end
            end
            exp_rdy = (i < 16) ? (i % 8 == 0) : 1'b1;
            checks++;
            if (ready_out !== exp_rdy) begin
              failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, ready_out, exp_rdy);
            end
          end
        end
      end
    join
    exp_q.delete();
  endtask

  task automatic test_lsb_first;
    bit acc, found;
    logic [2:0] e;
    acc = 1'b0;
    din10 = 10'h201;
    vin10 = 1'b1;
    push_bits({6'h00, 10'h201}, 10, 1'b0, 1'b1);
    for (int t = 0; t < 40 && !acc; t++) begin
      if (rdy10) begin @(posedge dclk); acc = 1'b1; end
      else @(negedge dclk);
    end
    #1 vin10 = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(posedge dclk); @(negedge dclk);
      found = sof10 && vout10;
    end
    checks++;
    if (!acc || !found) begin
      failures++; $display("FAIL lsb_start got=acc%0d/found%0d exp=1/1", acc, found); exp_q.delete();
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (i > 0) begin @(posedge dclk); @(negedge dclk); end
        e = exp_q.pop_front();
        checks++;
        if ({dout10, vout10, sof10} !== e) begin
          failures++; $display("FAIL lsb_bit%0d got=%b exp=%b", i, {dout10, vout10, sof10}, e);
        end
      end
    end
  endtask

  task automatic test_enable_hold;
    bit acc, found;
    logic [2:0] e;
    @(negedge dclk);
    send_word(8'h3C, acc);
    push_bits(16'h003C, 8, 1'b1, 1'b1);
    found = 1'b0;
    for (int t = 0; t < 24 && !found; t++) begin
      @(posedge dclk); @(negedge dclk);
      found = sof_out && valid_out;
    end
    checks++;
    if (!acc || !found) begin
      failures++; $display("FAIL hold_start got=acc%0d/found%0d exp=1/1", acc, found); exp_q.delete();
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) begin @(posedge dclk); @(negedge dclk); end
        e = exp_q.pop_front();
        checks++;
        if ({data_out, valid_out, sof_out} !== e) begin
          failures++; $display("FAIL hold_bit%0d got=%b exp=%b", i, {data_out, valid_out, sof_out}, e);
        end
        if (i == 2) begin
          enable = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(posedge dclk); @(negedge dclk);
            checks++;
            if ({data_out, valid_out, sof_out} !== 3'b110) begin
              failures++; $display("FAIL hold_frozen%0d got=%b exp=110", s, {data_out, valid_out, sof_out});
            end
          end
          enable = 1'b1;
        end
      end
      @(posedge dclk); @(negedge dclk);
      checks++;
      if ({data_out, valid_out, sof_out} !== 3'b101) begin
        failures++; $display("FAIL hold_next_word got=%b exp=101", {data_out, valid_out, sof_out});
      end
    end
  endtask

  task automatic test_reset_midword;
    bit acc, found;
    logic [2:0] e;
    @(negedge dclk);
    send_word(8'h3C, acc);
    found = 1'b0;
    for (int t = 0; t < 24 && !found; t++) begin
      @(posedge dclk); @(negedge dclk);
      found = sof_out && valid_out;
    end
    checks++;
    if (!acc || !found) begin
      failures++; $display("FAIL rstmid_start got=acc%0d/found%0d exp=1/1", acc, found);
    end
    send_word(8'h55, acc);
    checks++;
    if (ready_out !== 1'b0) begin
      failures++; $display("FAIL rstmid_held got=%b exp=0", ready_out);
    end
    @(posedge dclk);
    @(negedge dclk) rst = 1'b1;
    #1;
    checks++;
    if ({data_out, valid_out, sof_out, ready_out} !== 4'b0001) begin
      failures++; $display("FAIL rstmid_immediate got=%b exp=0001", {data_out, valid_out, sof_out, ready_out});
    end
    @(posedge dclk); #1;
    checks++;
    if ({data_out, valid_out, sof_out, ready_out} !== 4'b0001) begin
      failures++; $display("FAIL rstmid_during got=%b exp=0001", {data_out, valid_out, sof_out, ready_out});
    end
    @(negedge dclk) rst = 1'b0;
    push_bits(16'h00BC, 8, 1'b1, 1'b0);
    push_bits(16'h00BC, 1, 1'b1, 1'b0);
    exp_q[8] = 3'b101;
    for (int i = 0; i < 9; i++) begin
      @(posedge dclk); @(negedge dclk);
      e = exp_q.pop_front();
      checks++;
      if ({data_out, valid_out, sof_out} !== e) begin
        failures++; $display("FAIL rstmid_idle%0d got=%b exp=%b", i, {data_out, valid_out, sof_out}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_enable_hold();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
